gaussian: RTL and testbench

- 3x3 Gaussian smoothing kernel for one pixel neighbourhood per transaction. Kernel is [1 2 1; 2 4 2; 1 2 1]/16.
- Used by the image-blur controller: the controller gathers a 3x3 window from BRAM, pulses data_valid_in, then writes data_out to the output BRAM when data_valid_out pulses.
- Two-stage registered datapath with single-transaction occupancy.

---
 rtl/gaussian.sv | 78 +++++++
 tb/tb_gaussian.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/gaussian.sv
// 3x3 Gaussian smoothing kernel [1 2 1; 2 4 2; 1 2 1]/16, two registered stages, one transaction in flight.
// Optional macro GAUSSIAN_ROUND_EN selects round-half-up; otherwise the result is truncated.
module gaussian #(
  parameter int WIDTH = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [3*WIDTH-1:0] r0_data_in,
  input  logic [3*WIDTH-1:0] r1_data_in,
  input  logic [3*WIDTH-1:0] r2_data_in,
  input  logic               data_valid_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               data_valid_out,
  output logic               error_out,
  output logic               busy_out
);

  localparam int SW = WIDTH + 2;
  localparam int TW = WIDTH + 4;

  // Horizontal [1 2 1] pass over one row; 4*max fits in WIDTH+2 bits.
  function automatic logic [SW-1:0] row_sum(input logic [3*WIDTH-1:0] row);
    return SW'(row[3*WIDTH-1:2*WIDTH]) + (SW'(row[2*WIDTH-1:WIDTH]) << 1) + SW'(row[WIDTH-1:0]);
  endfunction

  logic [SW-1:0]    s0_q, s1_q, s2_q;
  logic             s_valid_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             error_q;

  logic             accept_d;
  logic             reject_d;
  logic [TW-1:0]    total_d;
  logic [WIDTH-1:0] data_d;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    accept_d = data_valid_in && !s_valid_q;
    reject_d = data_valid_in && s_valid_q;
    total_d  = TW'(s0_q) + (TW'(s1_q) << 1) + TW'(s2_q);
`ifdef GAUSSIAN_ROUND_EN
    data_d   = WIDTH'((total_d + TW'(8)) >> 4);
`else
    data_d   = WIDTH'(total_d >> 4);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s0_q      <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      s_valid_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      if (accept_d) begin
        s0_q <= row_sum(r0_data_in);
        s1_q <= row_sum(r1_data_in);
        s2_q <= row_sum(r2_data_in);
      end
      s_valid_q <= accept_d;
      valid_q   <= s_valid_q;
      error_q   <= reject_d;
      // data_out holds between transactions; it only moves when stage 2 fires.
      if (s_valid_q) data_q <= data_d;
    end
  end

  assign data_out       = data_q;
  assign data_valid_out = valid_q;
  assign error_out      = error_q;
  assign busy_out       = s_valid_q;

endmodule

// File: tb/tb_gaussian.sv
// Self-checking bench for gaussian: directed corner windows, handshake cases and random windows
// compared against a weighted-sum reference model.
module tb_gaussian;

  localparam int W = 8;

  logic           clk_in = 1'b0;
  logic           rst_in = 1'b0;
  logic [3*W-1:0] r0_data_in = '0, r1_data_in = '0, r2_data_in = '0;
  logic           data_valid_in = 1'b0;
  logic [W-1:0]   data_out;
  logic           data_valid_out, error_out, busy_out;

  int checks = 0;
  int errors = 0;

  gaussian #(.WIDTH(W)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .r0_data_in    (r0_data_in),
    .r1_data_in    (r1_data_in),
    .r2_data_in    (r2_data_in),
    .data_valid_in (data_valid_in),
    .data_out      (data_out),
    .data_valid_out(data_valid_out),
    .error_out     (error_out),
    .busy_out      (busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1ns so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Reference: full 3x3 weighted sum, then divide by 16 with rounding or truncation.
  function automatic int model(input logic [3*W-1:0] a, input logic [3*W-1:0] b, input logic [3*W-1:0] c);
    int px[3][3];
    int total = 0;
    for (int col = 0; col < 3; col++) begin
      px[0][col] = int'(a[(2-col)*W +: W]);
      px[1][col] = int'(b[(2-col)*W +: W]);
      px[2][col] = int'(c[(2-col)*W +: W]);
    end
    for (int r = 0; r < 3; r++)
      for (int col = 0; col < 3; col++)
        total += px[r][col] * ((r == 1) ? 2 : 1) * ((col == 1) ? 2 : 1);
`ifdef GAUSSIAN_ROUND_EN
    return (total + 8) / 16;
`else
    return total / 16;
`endif
  endfunction

  function automatic logic [3*W-1:0] row(input int l, input int c, input int r);
    return {W'(l), W'(c), W'(r)};
  endfunction

  task automatic drive(input logic [3*W-1:0] a, input logic [3*W-1:0] b, input logic [3*W-1:0] c);
    r0_data_in    = a;
    r1_data_in    = b;
    r2_data_in    = c;
    data_valid_in = 1'b1;
  endtask

  // Full transaction: strobe, check the busy cycle, check the result cycle, check the hold cycle.
  task automatic run_txn(input string tag, input logic [3*W-1:0] a, input logic [3*W-1:0] b,
                         input logic [3*W-1:0] c, input int exp);
    drive(a, b, c);
    step();
    data_valid_in = 1'b0;
    r0_data_in = $urandom;  // rows may change freely after acceptance
    r1_data_in = $urandom;
    r2_data_in = $urandom;
    check({tag, ".busy"}, 32'(busy_out), 1);
    check({tag, ".dvo_early"}, 32'(data_valid_out), 0);
    step();
    check({tag, ".dvo"}, 32'(data_valid_out), 1);
    check({tag, ".data"}, 32'(data_out), 32'(exp));
    check({tag, ".idle"}, 32'(busy_out), 0);
    step();
    check({tag, ".dvo_low"}, 32'(data_valid_out), 0);
    check({tag, ".hold"}, 32'(data_out), 32'(exp));
  endtask

  initial begin
    logic [3*W-1:0] a, b, c;
    int exp1, exp2;

    // Reset state.
    #2;
    check("rst.data", 32'(data_out), 0);
    check("rst.dvo", 32'(data_valid_out), 0);
    check("rst.err", 32'(error_out), 0);
    check("rst.busy", 32'(busy_out), 0);
    step();
    rst_in = 1'b1;
    step();

    // Directed windows.
    run_txn("uniform100", row(100,100,100), row(100,100,100), row(100,100,100), 100);
`ifdef GAUSSIAN_ROUND_EN
    run_txn("centre255", row(0,0,0), row(0,255,0), row(0,0,0), 64);
`else
    run_txn("centre255", row(0,0,0), row(0,255,0), row(0,0,0), 63);
`endif
    run_txn("all255", row(255,255,255), row(255,255,255), row(255,255,255), 255);
    run_txn("all0", row(0,0,0), row(0,0,0), row(0,0,0), 0);
    run_txn("asym", row(10,20,30), row(40,50,60), row(70,80,90), 50);
    run_txn("asym_swap", row(90,80,70), row(60,50,40), row(30,20,10), 50);

    // Strobes on two consecutive cycles: second is dropped with one error pulse.
    a = row(12,200,7); b = row(99,3,250); c = row(64,128,1);
    exp1 = model(a, b, c);
    drive(a, b, c);
    step();
    drive(row(255,255,255), row(255,255,255), row(255,255,255));
    step();
    data_valid_in = 1'b0;
    check("b2b.dvo", 32'(data_valid_out), 1);
    check("b2b.data", 32'(data_out), 32'(exp1));
    check("b2b.err", 32'(error_out), 1);
    step();
    check("b2b.err_once", 32'(error_out), 0);
    check("b2b.dvo_once", 32'(data_valid_out), 0);
    check("b2b.busy", 32'(busy_out), 0);
    step();
    check("b2b.no_second", 32'(data_valid_out), 0);

    // Strobe in the data_valid_out cycle is accepted.
    a = row(1,2,3); b = row(4,5,6); c = row(7,8,9);
    exp1 = model(a, b, c);
    drive(a, b, c);
    step();
    data_valid_in = 1'b0;
    step();
    check("chain.dvo1", 32'(data_valid_out), 1);
    check("chain.data1", 32'(data_out), 32'(exp1));
    a = row(200,17,33); b = row(5,240,77); c = row(150,150,9);
    exp2 = model(a, b, c);
    drive(a, b, c);
    step();
    data_valid_in = 1'b0;
    check("chain.busy2", 32'(busy_out), 1);
    check("chain.err2", 32'(error_out), 0);
    check("chain.hold1", 32'(data_out), 32'(exp1));
    step();
    check("chain.dvo2", 32'(data_valid_out), 1);
    check("chain.data2", 32'(data_out), 32'(exp2));
    step();

    // Reset during the busy cycle discards the transaction.
    drive(row(255,255,255), row(255,255,255), row(255,255,255));
    step();
    data_valid_in = 1'b0;
    check("midrst.busy", 32'(busy_out), 1);
    rst_in = 1'b0;
    #1;
    check("midrst.data", 32'(data_out), 0);
    check("midrst.dvo", 32'(data_valid_out), 0);
    check("midrst.busy0", 32'(busy_out), 0);
    check("midrst.err", 32'(error_out), 0);
    step();
    rst_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("midrst.no_valid", 32'(data_valid_out), 0);
    end

    // Random windows against the model.
    for (int i = 0; i < 25; i++) begin
      a = {W'($urandom), W'($urandom), W'($urandom)};
      b = {W'($urandom), W'($urandom), W'($urandom)};
      c = {W'($urandom), W'($urandom), W'($urandom)};
      run_txn($sformatf("rand%0d", i), a, b, c, model(a, b, c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
